// File: rtl/flyback_ctrl_regbank_if.sv
// AXI4-Lite bundle for the flyback controller register bank.
// The bench drives the bank through this interface.
interface flyback_ctrl_regbank_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/flyback_ctrl_regbank.sv
// AXI4-Lite register bank for the flyback controller: RW control words with
// write strobes, RO status words, independent AW/W skid slots, 2-state read FSM.
module flyback_ctrl_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_NUM_RW_REGS      = 8,
  parameter int C_NUM_RO_REGS      = 4,
  parameter logic [C_NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] C_RW_RST_VAL = '0,
  localparam int ADDR_LSB           = $clog2(C_S_AXI_DATA_WIDTH/8),
  localparam int NUM_REGS           = C_NUM_RW_REGS + C_NUM_RO_REGS,
  localparam int IDX_W              = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int C_S_AXI_ADDR_WIDTH = ADDR_LSB + IDX_W,
  localparam int RO_SLOTS           = (C_NUM_RO_REGS > 0) ? C_NUM_RO_REGS : 1
) (
  input  logic                                        S_AXI_ACLK,
  input  logic                                        S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_AWADDR,
  input  logic [2:0]                                  S_AXI_AWPROT,
  input  logic                                        S_AXI_AWVALID,
  output logic                                        S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]             S_AXI_WSTRB,
  input  logic                                        S_AXI_WVALID,
  output logic                                        S_AXI_WREADY,
  output logic [1:0]                                  S_AXI_BRESP,
  output logic                                        S_AXI_BVALID,
  input  logic                                        S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]               S_AXI_ARADDR,
  input  logic [2:0]                                  S_AXI_ARPROT,
  input  logic                                        S_AXI_ARVALID,
  output logic                                        S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               S_AXI_RDATA,
  output logic [1:0]                                  S_AXI_RRESP,
  output logic                                        S_AXI_RVALID,
  input  logic                                        S_AXI_RREADY,
  output logic [C_NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
  output logic [C_NUM_RW_REGS-1:0]                    ctrl_wr_pulse_o,
  input  logic [RO_SLOTS*C_S_AXI_DATA_WIDTH-1:0]      status_i
);

  localparam int W  = C_S_AXI_DATA_WIDTH;
  localparam int NB = W / 8;
  localparam logic [IDX_W:0] NRW_I = (IDX_W+1)'(C_NUM_RW_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  logic                            ready_q, ready_d;
  logic                            aw_full_q, aw_full_d;
  logic [IDX_W-1:0]                aw_idx_q, aw_idx_d;
  logic                            w_full_q, w_full_d;
  logic [W-1:0]                    w_data_q, w_data_d;
  logic [NB-1:0]                   w_strb_q, w_strb_d;
  logic                            bvalid_q, bvalid_d;
  logic [1:0]                      bresp_q, bresp_d;
  logic [C_NUM_RW_REGS-1:0]        pulse_q, pulse_d;
  logic [C_NUM_RW_REGS-1:0][W-1:0] regs_q, regs_d;
  rd_state_e                       rd_state_q, rd_state_d;
  logic [W-1:0]                    rdata_q, rdata_d;
  logic [1:0]                      rresp_q, rresp_d;

  logic             aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0] ar_idx;
  logic             unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Ready outputs are held low until the first edge after reset release.
  assign S_AXI_AWREADY = ready_q & ~aw_full_q;
  assign S_AXI_WREADY  = ready_q & ~w_full_q;
  assign S_AXI_ARREADY = ready_q & (rd_state_q == RD_IDLE);
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (rd_state_q == RD_RESP);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ctrl_o          = regs_q;
  assign ctrl_wr_pulse_o = pulse_q;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_full_q & w_full_q & ~bvalid_q;
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];

  always_comb begin
    ready_d   = 1'b1;
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    pulse_d   = '0;
    regs_d    = regs_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end
    if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // A handshake needs an empty slot and a commit needs both full, so they never collide.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_SLVERR;
      for (int unsigned k = 0; k < C_NUM_RW_REGS; k++) begin
        if ({1'b0, aw_idx_q} == (IDX_W+1)'(k)) begin
          bresp_d    = RESP_OKAY;
          pulse_d[k] = 1'b1;
          for (int unsigned b = 0; b < NB; b++) begin
            if (w_strb_q[b]) regs_d[k][b*8 +: 8] = w_data_q[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = RD_RESP;
          rdata_d    = '0;
          rresp_d    = RESP_SLVERR;
          for (int unsigned k = 0; k < C_NUM_RW_REGS; k++) begin
            if ({1'b0, ar_idx} == (IDX_W+1)'(k)) begin
              rdata_d = regs_q[k];
              rresp_d = RESP_OKAY;
            end
          end
          for (int unsigned k = 0; k < C_NUM_RO_REGS; k++) begin
            if ({1'b0, ar_idx} == NRW_I + (IDX_W+1)'(k)) begin
              rdata_d = status_i[k*W +: W];
              rresp_d = RESP_OKAY;
            end
          end
        end
      end
      RD_RESP: begin
        if (S_AXI_RREADY) rd_state_d = RD_IDLE;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ready_q    <= 1'b0;
      aw_full_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_full_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      pulse_q    <= '0;
      regs_q     <= C_RW_RST_VAL;
      rd_state_q <= RD_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      ready_q    <= ready_d;
      aw_full_q  <= aw_full_d;
      aw_idx_q   <= aw_idx_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      pulse_q    <= pulse_d;
      regs_q     <= regs_d;
      rd_state_q <= rd_state_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_flyback_ctrl_regbank.sv
// Directed self-checking bench for flyback_ctrl_regbank (32-bit, 8 RW, 4 RO).
module tb_flyback_ctrl_regbank;

  localparam logic [255:0] RST_IMG = {32'hC0DE0007, 32'hC0DE0006, 32'hC0DE0005, 32'hC0DE0004,
                                      32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};

  logic         clk;
  logic         rst_n;
  logic [255:0] ctrl;
  logic [7:0]   pulse;
  logic [127:0] status;
  int           n_checks;
  int           n_errors;
  logic [1:0]   r;
  logic [7:0]   p;
  logic [255:0] snap;

  flyback_ctrl_regbank_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  flyback_ctrl_regbank #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_NUM_RW_REGS(8),
    .C_NUM_RO_REGS(4),
    .C_RW_RST_VAL(RST_IMG)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(bus.AWADDR),
    .S_AXI_AWPROT(bus.AWPROT),
    .S_AXI_AWVALID(bus.AWVALID),
    .S_AXI_AWREADY(bus.AWREADY),
    .S_AXI_WDATA(bus.WDATA),
    .S_AXI_WSTRB(bus.WSTRB),
    .S_AXI_WVALID(bus.WVALID),
    .S_AXI_WREADY(bus.WREADY),
    .S_AXI_BRESP(bus.BRESP),
    .S_AXI_BVALID(bus.BVALID),
    .S_AXI_BREADY(bus.BREADY),
    .S_AXI_ARADDR(bus.ARADDR),
    .S_AXI_ARPROT(bus.ARPROT),
    .S_AXI_ARVALID(bus.ARVALID),
    .S_AXI_ARREADY(bus.ARREADY),
    .S_AXI_RDATA(bus.RDATA),
    .S_AXI_RRESP(bus.RRESP),
    .S_AXI_RVALID(bus.RVALID),
    .S_AXI_RREADY(bus.RREADY),
    .ctrl_o(ctrl),
    .ctrl_wr_pulse_o(pulse),
    .status_i(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input int idx);
    int n = 0;
    bus.AWADDR  = 6'(idx * 4 + 2);
    bus.AWVALID = 1'b1;
    while (!bus.AWREADY && n < 20) begin step(); n++; end
    step();
    bus.AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.WDATA  = d;
    bus.WSTRB  = s;
    bus.WVALID = 1'b1;
    while (!bus.WREADY && n < 20) begin step(); n++; end
    step();
    bus.WVALID = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    while (!bus.BVALID && n < 20) begin step(); n++; end
    chk("bvalid_seen", bus.BVALID, 1'b1);
  endtask

  task automatic ack_b();
    bus.BREADY = 1'b1;
    step();
    bus.BREADY = 1'b0;
  endtask

  task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [7:0] pls);
    int  n = 0;
    logic aw_go, w_go;
    bus.AWADDR  = 6'(idx * 4 + 2);
    bus.AWVALID = 1'b1;
    bus.WDATA   = d;
    bus.WSTRB   = s;
    bus.WVALID  = 1'b1;
    while ((bus.AWVALID || bus.WVALID) && n < 20) begin
      aw_go = bus.AWVALID & bus.AWREADY;
      w_go  = bus.WVALID & bus.WREADY;
      step();
      if (aw_go) bus.AWVALID = 1'b0;
      if (w_go)  bus.WVALID  = 1'b0;
      n++;
    end
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    wait_b();
    resp = bus.BRESP;
    pls  = pulse;
    ack_b();
  endtask

  task automatic do_read(input int idx, input logic [31:0] exp_d, input logic [1:0] exp_r);
    int n = 0;
    bus.ARADDR  = 6'(idx * 4);
    bus.ARVALID = 1'b1;
    while (!bus.ARREADY && n < 20) begin step(); n++; end
    step();
    bus.ARVALID = 1'b0;
    chk($sformatf("rd%0d_rvalid", idx), bus.RVALID, 1'b1);
    chk($sformatf("rd%0d_rdata", idx), bus.RDATA, exp_d);
    chk($sformatf("rd%0d_rresp", idx), bus.RRESP, exp_r);
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;
    chk($sformatf("rd%0d_rvalid_drop", idx), bus.RVALID, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    status = {32'hFEED0004, 32'hFEED0003, 32'hFEED0002, 32'h5A5A0001};
    step(); step(); step();

    // Reset state
    chk("rst_awready", bus.AWREADY, 1'b0);
    chk("rst_wready", bus.WREADY, 1'b0);
    chk("rst_arready", bus.ARREADY, 1'b0);
    chk("rst_bvalid", bus.BVALID, 1'b0);
    chk("rst_rvalid", bus.RVALID, 1'b0);
    chk("rst_bresp", bus.BRESP, 2'b00);
    chk("rst_rresp", bus.RRESP, 2'b00);
    chk("rst_rdata", bus.RDATA, 32'h0);
    chk("rst_ctrl", ctrl, RST_IMG);
    chk("rst_pulse", pulse, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("rel_awready_before_edge", bus.AWREADY, 1'b0);
    step();
    chk("rel_awready", bus.AWREADY, 1'b1);
    chk("rel_wready", bus.WREADY, 1'b1);
    chk("rel_arready", bus.ARREADY, 1'b1);

    // Reset image readback
    for (int k = 0; k < 8; k++) do_read(k, 32'hC0DE0000 + 32'(k), 2'b00);

    // W two cycles ahead of AW
    bus.WDATA = 32'hdead0011; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    step();
    bus.WVALID = 1'b0;
    chk("w_slot_full", bus.WREADY, 1'b0);
    step();
    bus.AWADDR = 6'd8; bus.AWVALID = 1'b1;
    chk("aw_ready_w_first", bus.AWREADY, 1'b1);
    step();
    bus.AWVALID = 1'b0;
    chk("b_not_yet", bus.BVALID, 1'b0);
    step();
    chk("b_rise", bus.BVALID, 1'b1);
    chk("b_okay", bus.BRESP, 2'b00);
    chk("pulse2", pulse, 8'h04);
    chk("ctrl2", ctrl[2*32 +: 32], 32'hdead0011);
    step();
    chk("pulse2_one_cycle", pulse, 8'h00);
    chk("b_held", bus.BVALID, 1'b1);
    ack_b();
    chk("b_acked", bus.BVALID, 1'b0);
    do_read(2, 32'hdead0011, 2'b00);

    // Byte strobes
    axi_write(1, 32'habcd0001, 4'hF, r, p);
    chk("w1_resp", r, 2'b00);
    chk("w1_pulse", p, 8'h02);
    axi_write(1, 32'h0101FFFF, 4'b0110, r, p);
    do_read(1, 32'hab01FF01, 2'b00);
    axi_write(1, 32'habcd0001, 4'hF, r, p);
    axi_write(1, 32'h0101FFFF, 4'b0101, r, p);
    do_read(1, 32'hab0100FF, 2'b00);
    axi_write(1, 32'h12345678, 4'b0000, r, p);
    chk("strb0_pulse", p, 8'h02);
    chk("strb0_resp", r, 2'b00);
    chk("strb0_ctrl", ctrl[1*32 +: 32], 32'hab0100FF);

    // RO and unmapped writes/reads
    snap = ctrl;
    axi_write(9, 32'hFFFFFFFF, 4'hF, r, p);
    chk("ro_wr_resp", r, 2'b10);
    chk("ro_wr_pulse", p, 8'h00);
    chk("ro_wr_ctrl", ctrl, snap);
    axi_write(15, 32'hFFFFFFFF, 4'hF, r, p);
    chk("um_wr_resp", r, 2'b10);
    chk("um_wr_pulse", p, 8'h00);
    chk("um_wr_ctrl", ctrl, snap);
    do_read(15, 32'h0, 2'b10);
    do_read(12, 32'h0, 2'b10);
    do_read(8, 32'h5A5A0001, 2'b00);
    do_read(11, 32'hFEED0004, 2'b00);

    // B backpressure blocks the next commit
    send_aw(3);
    send_w(32'h11112222, 4'hF);
    wait_b();
    chk("bp_pulse3", pulse, 8'h08);
    chk("bp_ctrl3", ctrl[3*32 +: 32], 32'h11112222);
    send_aw(3);
    send_w(32'h33334444, 4'hF);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_bvalid_hold", bus.BVALID, 1'b1);
      chk("bp_bresp_hold", bus.BRESP, 2'b00);
      chk("bp_ctrl3_hold", ctrl[3*32 +: 32], 32'h11112222);
      chk("bp_aw_slot_full", bus.AWREADY, 1'b0);
    end
    ack_b();
    chk("bp_b_acked", bus.BVALID, 1'b0);
    chk("bp_ctrl3_not_yet", ctrl[3*32 +: 32], 32'h11112222);
    step();
    chk("bp_second_b", bus.BVALID, 1'b1);
    chk("bp_second_pulse", pulse, 8'h08);
    chk("bp_ctrl3_new", ctrl[3*32 +: 32], 32'h33334444);
    ack_b();

    // R backpressure, with a write running concurrently
    bus.ARADDR = 6'd12; bus.ARVALID = 1'b1;
    step();
    bus.ARVALID = 1'b0;
    axi_write(3, 32'h55556666, 4'hF, r, p);
    chk("conc_wr_resp", r, 2'b00);
    chk("conc_ctrl3", ctrl[3*32 +: 32], 32'h55556666);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rp_rvalid_hold", bus.RVALID, 1'b1);
      chk("rp_rdata_hold", bus.RDATA, 32'h33334444);
      chk("rp_arready_low", bus.ARREADY, 1'b0);
    end
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;
    chk("rp_rvalid_drop", bus.RVALID, 1'b0);
    do_read(3, 32'h55556666, 2'b00);

    // Reset mid-transaction
    send_aw(0);
    send_w(32'haaaa5555, 4'hF);
    wait_b();
    chk("mr_ctrl0", ctrl[31:0], 32'haaaa5555);
    bus.WDATA = 32'hbbbbbbbb; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    step();
    bus.WVALID = 1'b0;
    chk("mr_w_slot_full", bus.WREADY, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mr_bvalid", bus.BVALID, 1'b0);
    chk("mr_ctrl", ctrl, RST_IMG);
    chk("mr_wready", bus.WREADY, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("mr_wready_back", bus.WREADY, 1'b1);
    send_aw(5);
    step(); step(); step();
    chk("mr_no_stale_w", bus.BVALID, 1'b0);
    chk("mr_ctrl5_untouched", ctrl[5*32 +: 32], 32'hC0DE0005);
    send_w(32'h12345678, 4'hF);
    wait_b();
    chk("mr_resp", bus.BRESP, 2'b00);
    chk("mr_pulse5", pulse, 8'h20);
    ack_b();
    do_read(5, 32'h12345678, 2'b00);
    do_read(0, 32'hC0DE0000, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
